scsp_timer_bank: RTL and testbench

Parametrised bank of SCSP sample-rate interval timers, the generalised successor of the fixed three-timer TIMA/TIMB/TIMC group. It holds NUM_TIMERS up-counters of CNT_W bits, all stepped from one shared power-of-two prescaler driven by the sample tick. Each timer raises a one-cycle overflow pulse that feeds the SCIPD/MCIPD pending logic. Unlike the fixed group, it adds a per-timer auto-reload mode and read-back of the live count.

---
 rtl/scsp_timer_bank_if.sv | 27 ++
 rtl/scsp_timer_bank.sv | 66 ++++++
 tb/tb_scsp_timer_bank.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scsp_timer_bank_if.sv
// scsp_timer_bank_if: write/read/irq bus of the SCSP interval timer bank
interface scsp_timer_bank_if #(
  parameter int NUM_TIMERS = 3,
  parameter int CNT_W = 8,
  parameter int PRE_W = 3
);
  localparam int SEL_W = NUM_TIMERS > 1 ? $clog2(NUM_TIMERS) : 1;
  logic ce;
  logic sample_tick;
  logic wr;
  logic [SEL_W-1:0] wr_sel;
  logic [CNT_W-1:0] wr_val;
  logic [PRE_W-1:0] wr_ctl;
  logic wr_rld;
  logic [SEL_W-1:0] rd_sel;
  logic [CNT_W-1:0] rd_val;
  logic [PRE_W-1:0] rd_ctl;
  logic [NUM_TIMERS-1:0] irq;
  modport master (
    output ce, sample_tick, wr, wr_sel, wr_val, wr_ctl, wr_rld, rd_sel,
    input rd_val, rd_ctl, irq
  );
  modport slave (
    input ce, sample_tick, wr, wr_sel, wr_val, wr_ctl, wr_rld, rd_sel,
    output rd_val, rd_ctl, irq
  );
endinterface

// File: rtl/scsp_timer_bank.sv
// scsp_timer_bank: NUM_TIMERS sample-rate up-counters sharing one power-of-two prescaler
module scsp_timer_bank #(
  parameter int NUM_TIMERS = 3,
  parameter int CNT_W = 8,
  parameter int PRE_W = 3
) (
  input logic clk,
  input logic rst_n,
  scsp_timer_bank_if.slave bus
);
  localparam int SEL_W = NUM_TIMERS > 1 ? $clog2(NUM_TIMERS) : 1;
  localparam int PW = (1 << PRE_W) - 1;
  logic [PW-1:0] p;
  logic [CNT_W-1:0] cnt [NUM_TIMERS];
  logic [CNT_W-1:0] rldv [NUM_TIMERS];
  logic [PRE_W-1:0] ctl [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] mode, irq, step, we;
  logic tick;
  assign tick = bus.ce & bus.sample_tick;
  // a timer steps when the low CTL bits of the pre-increment prescaler are all zero
  always_comb begin
    step = '0;
    we = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      step[i] = tick && ((p & PW'(((PW+1)'(1) << ctl[i]) - (PW+1)'(1))) == '0);
      we[i] = bus.ce && bus.wr && bus.wr_sel == SEL_W'(i);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p <= '0;
      irq <= '0;
      mode <= '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        cnt[i] <= '0;
        rldv[i] <= '0;
        ctl[i] <= '0;
      end
    end else begin
      irq <= '0;
      if (tick) p <= p + 1'b1;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (we[i]) begin
          cnt[i] <= bus.wr_val;
          rldv[i] <= bus.wr_val;
          ctl[i] <= bus.wr_ctl;
          mode[i] <= bus.wr_rld;
        end else if (step[i]) begin
          cnt[i] <= &cnt[i] ? (mode[i] ? rldv[i] : '0) : cnt[i] + 1'b1;
          irq[i] <= &cnt[i];
        end
      end
    end
  end
  always_comb begin
    bus.rd_val = '0;
    bus.rd_ctl = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (bus.rd_sel == SEL_W'(i)) begin
        bus.rd_val = cnt[i];
        bus.rd_ctl = ctl[i];
      end
    end
  end
  assign bus.irq = irq;
endmodule

// File: tb/tb_scsp_timer_bank.sv
// tb_scsp_timer_bank: directed checks of a 3x8-bit bank and a 5x4-bit bank
module tb_scsp_timer_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  logic [7:0] va;
  logic [3:0] vb;
  logic [2:0] ca;
  always #5 clk = ~clk;
  scsp_timer_bank_if #(.NUM_TIMERS(3), .CNT_W(8), .PRE_W(3)) ia ();
  scsp_timer_bank_if #(.NUM_TIMERS(5), .CNT_W(4), .PRE_W(3)) ib ();
  scsp_timer_bank #(.NUM_TIMERS(3), .CNT_W(8), .PRE_W(3)) ua (.clk(clk), .rst_n(rst_n), .bus(ia));
  scsp_timer_bank #(.NUM_TIMERS(5), .CNT_W(4), .PRE_W(3)) ub (.clk(clk), .rst_n(rst_n), .bus(ib));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_a();
    ia.sample_tick = 1'b1;
    cyc();
    ia.sample_tick = 1'b0;
  endtask

  task automatic tick_b();
    ib.sample_tick = 1'b1;
    cyc();
    ib.sample_tick = 1'b0;
  endtask

  task automatic write_a(input logic [1:0] s, input logic [7:0] v, input logic [2:0] c, input logic r);
    ia.wr = 1'b1;
    ia.wr_sel = s;
    ia.wr_val = v;
    ia.wr_ctl = c;
    ia.wr_rld = r;
    cyc();
    ia.wr = 1'b0;
  endtask

  task automatic read_a(input logic [1:0] s, output logic [7:0] v, output logic [2:0] c);
    ia.rd_sel = s;
    #1;
    v = ia.rd_val;
    c = ia.rd_ctl;
  endtask

  task automatic read_b(input logic [2:0] s, output logic [3:0] v);
    ib.rd_sel = s;
    #1;
    v = ib.rd_val;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++;
    if (ia.irq !== 3'b000) begin fails++; $display("FAIL reset_irq got %b want 000", ia.irq); end
    for (int i = 0; i < 3; i++) begin
      read_a(2'(i), va, ca);
      checks++;
      if (va !== 8'h00 || ca !== 3'd0) begin fails++; $display("FAIL reset_state t%0d got %h/%0d want 00/0", i, va, ca); end
    end
    rst_n = 1'b1;
    repeat (3) tick_a();
    checks++;
    if (ia.irq !== 3'b000) begin fails++; $display("FAIL three_ticks_irq got %b want 000", ia.irq); end
    for (int i = 0; i < 3; i++) begin
      read_a(2'(i), va, ca);
      checks++;
      if (va !== 8'h03) begin fails++; $display("FAIL three_ticks t%0d got %h want 03", i, va); end
    end
  endtask

  task automatic test_free_run();
    write_a(2'd0, 8'hFD, 3'd0, 1'b0);
    read_a(2'd0, va, ca);
    checks++;
    if (va !== 8'hFD) begin fails++; $display("FAIL readback got %h want fd", va); end
    tick_a();
    tick_a();
    read_a(2'd0, va, ca);
    checks++;
    if (va !== 8'hFF || ia.irq !== 3'b000) begin fails++; $display("FAIL pre_overflow got %h/%b want ff/000", va, ia.irq); end
    tick_a();
    read_a(2'd0, va, ca);
    checks++;
    if (va !== 8'h00 || ia.irq !== 3'b001) begin fails++; $display("FAIL wrap got %h/%b want 00/001", va, ia.irq); end
    cyc();
    checks++;
    if (ia.irq !== 3'b000) begin fails++; $display("FAIL irq_one_cycle got %b want 000", ia.irq); end
    tick_a();
    read_a(2'd0, va, ca);
    checks++;
    if (va !== 8'h01) begin fails++; $display("FAIL after_wrap got %h want 01", va); end
    read_a(2'd1, va, ca);
    checks++;
    if (va !== 8'h07) begin fails++; $display("FAIL other_timer got %h want 07", va); end
    read_a(2'd3, va, ca);
    checks++;
    if (va !== 8'h00 || ca !== 3'd0) begin fails++; $display("FAIL rd_out_of_range got %h/%0d want 00/0", va, ca); end
  endtask

  task automatic test_reload();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    write_a(2'd1, 8'hFF, 3'd2, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick_a();
      read_a(2'd1, va, ca);
      checks++;
      if (ia.irq !== ((k % 4 == 0) ? 3'b010 : 3'b000) || va !== 8'hFF || ca !== 3'd2) begin
        fails++;
        $display("FAIL reload p=%0d got %b/%h/%0d", k, ia.irq, va, ca);
      end
    end
    read_a(2'd0, va, ca);
    checks++;
    if (va !== 8'h08) begin fails++; $display("FAIL reload_t0 got %h want 08", va); end
  endtask

  task automatic test_write_wins();
    write_a(2'd2, 8'hFF, 3'd0, 1'b0);
    ia.wr = 1'b1;
    ia.wr_sel = 2'd2;
    ia.wr_val = 8'h10;
    ia.wr_ctl = 3'd0;
    ia.wr_rld = 1'b0;
    tick_a();
    ia.wr = 1'b0;
    checks++;
    if (ia.irq !== 3'b010) begin fails++; $display("FAIL write_wins_irq got %b want 010", ia.irq); end
    read_a(2'd2, va, ca);
    checks++;
    if (va !== 8'h10) begin fails++; $display("FAIL write_wins_t2 got %h want 10", va); end
    read_a(2'd0, va, ca);
    checks++;
    if (va !== 8'h09) begin fails++; $display("FAIL write_wins_t0 got %h want 09", va); end
    cyc();
    tick_a();
    read_a(2'd2, va, ca);
    checks++;
    if (va !== 8'h11 || ia.irq !== 3'b000) begin fails++; $display("FAIL post_write_step got %h/%b want 11/000", va, ia.irq); end
  endtask

  task automatic test_ce_gate();
    ia.ce = 1'b0;
    ia.sample_tick = 1'b1;
    ia.wr = 1'b1;
    ia.wr_sel = 2'd0;
    ia.wr_val = 8'h55;
    ia.wr_ctl = 3'd5;
    ia.wr_rld = 1'b1;
    repeat (3) cyc();
    ia.ce = 1'b1;
    ia.sample_tick = 1'b0;
    ia.wr = 1'b0;
    read_a(2'd0, va, ca);
    checks++;
    if (va !== 8'h0A || ca !== 3'd0 || ia.irq !== 3'b000) begin fails++; $display("FAIL ce_hold got %h/%0d/%b want 0a/0/000", va, ca, ia.irq); end
    tick_a();
    read_a(2'd2, va, ca);
    checks++;
    if (va !== 8'h12) begin fails++; $display("FAIL ce_resume got %h want 12", va); end
  endtask

  task automatic test_irq_clear_and_reset();
    write_a(2'd0, 8'hFF, 3'd0, 1'b0);
    tick_a();
    checks++;
    if (ia.irq !== 3'b001) begin fails++; $display("FAIL p11_irq got %b want 001", ia.irq); end
    ia.ce = 1'b0;
    cyc();
    ia.ce = 1'b1;
    checks++;
    if (ia.irq !== 3'b000) begin fails++; $display("FAIL irq_clear_ce0 got %b want 000", ia.irq); end
    write_a(2'd0, 8'hFF, 3'd0, 1'b0);
    write_a(2'd2, 8'hFF, 3'd0, 1'b0);
    tick_a();
    checks++;
    if (ia.irq !== 3'b111) begin fails++; $display("FAIL same_tick_irq got %b want 111", ia.irq); end
    write_a(2'd0, 8'hFF, 3'd0, 1'b0);
    rst_n = 1'b0;
    tick_a();
    checks++;
    if (ia.irq !== 3'b000) begin fails++; $display("FAIL reset_pending_irq got %b want 000", ia.irq); end
    for (int i = 0; i < 3; i++) begin
      read_a(2'(i), va, ca);
      checks++;
      if (va !== 8'h00 || ca !== 3'd0) begin fails++; $display("FAIL reset_clears t%0d got %h/%0d want 00/0", i, va, ca); end
    end
    rst_n = 1'b1;
    tick_a();
    for (int i = 0; i < 3; i++) begin
      read_a(2'(i), va, ca);
      checks++;
      if (va !== 8'h01 || ia.irq !== 3'b000) begin fails++; $display("FAIL post_reset t%0d got %h/%b want 01/000", i, va, ia.irq); end
    end
  endtask

  task automatic test_ctl7_wrap();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    write_a(2'd0, 8'hFE, 3'd7, 1'b0);
    repeat (128) tick_a();
    read_a(2'd0, va, ca);
    checks++;
    if (va !== 8'hFF || ca !== 3'd7 || ia.irq !== 3'b000) begin fails++; $display("FAIL ctl7_hold got %h/%0d/%b want ff/7/000", va, ca, ia.irq); end
    tick_a();
    read_a(2'd0, va, ca);
    checks++;
    if (va !== 8'h00 || ia.irq !== 3'b001) begin fails++; $display("FAIL ctl7_wrap got %h/%b want 00/001", va, ia.irq); end
    read_a(2'd1, va, ca);
    checks++;
    if (va !== 8'h81) begin fails++; $display("FAIL ctl0_count got %h want 81", va); end
  endtask

  task automatic test_wide_bank();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    ib.wr_val = 4'hE;
    ib.wr_ctl = 3'd0;
    ib.wr_rld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ib.wr = 1'b1;
      ib.wr_sel = 3'(i);
      cyc();
    end
    ib.wr_sel = 3'd6;
    ib.wr_val = 4'h3;
    ib.wr_ctl = 3'd1;
    cyc();
    ib.wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      read_b(3'(i), vb);
      checks++;
      if (vb !== 4'hE || ib.rd_ctl !== 3'd0) begin fails++; $display("FAIL bank5_load t%0d got %h/%0d want e/0", i, vb, ib.rd_ctl); end
    end
    tick_b();
    checks++;
    if (ib.irq !== 5'b00000) begin fails++; $display("FAIL bank5_first got %b want 00000", ib.irq); end
    tick_b();
    checks++;
    if (ib.irq !== 5'b11111) begin fails++; $display("FAIL bank5_overflow got %b want 11111", ib.irq); end
    for (int i = 0; i < 5; i++) begin
      read_b(3'(i), vb);
      checks++;
      if (vb !== 4'h0) begin fails++; $display("FAIL bank5_wrap t%0d got %h want 0", i, vb); end
    end
    cyc();
    checks++;
    if (ib.irq !== 5'b00000) begin fails++; $display("FAIL bank5_clear got %b want 00000", ib.irq); end
  endtask

  initial begin
    ia.ce = 1'b1;
    ia.sample_tick = 1'b0;
    ia.wr = 1'b0;
    ia.wr_sel = '0;
    ia.wr_val = '0;
    ia.wr_ctl = '0;
    ia.wr_rld = 1'b0;
    ia.rd_sel = '0;
    ib.ce = 1'b1;
    ib.sample_tick = 1'b0;
    ib.wr = 1'b0;
    ib.wr_sel = '0;
    ib.wr_val = '0;
    ib.wr_ctl = '0;
    ib.wr_rld = 1'b0;
    ib.rd_sel = '0;
    test_reset();
    test_free_run();
    test_reload();
    test_write_wins();
    test_ce_gate();
    test_irq_clear_and_reset();
    test_ctl7_wrap();
    test_wide_bank();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
